// File: rtl/dat_mem_pkg.sv
// Shared constants and types for the data memory with integrated hardware stack.
// Holds default geometry, the preloaded mask words and the stack-operation decode.
package dat_mem_pkg;

  localparam int DW_DEF        = 8;
  localparam int DEPTH_DEF     = 256;
  localparam int STK_DEPTH_DEF = 16;

  localparam int MASK_ADDR_0 = 60;
  localparam int MASK_ADDR_1 = 61;
  localparam int MASK_ADDR_2 = 62;

  localparam logic [7:0] MASK_VAL_0 = 8'h10;
  localparam logic [7:0] MASK_VAL_1 = 8'hE0;
  localparam logic [7:0] MASK_VAL_2 = 8'hF0;

  typedef enum logic [1:0] {
    STK_NOP,
    STK_PUSH,
    STK_POP,
    STK_REPL
  } stk_op_t;

  // push+pop on an empty stack degrades to a plain push
  function automatic stk_op_t stk_decode(input logic push, input logic pop, input logic empty);
    stk_op_t op;
    op = STK_NOP;
    if (push && pop) op = empty ? STK_PUSH : STK_REPL;
    else if (push)   op = STK_PUSH;
    else if (pop)    op = STK_POP;
    return op;
  endfunction

endpackage

// File: rtl/dat_mem_stk_ctrl.sv
// Stack controller: stack pointer, occupancy, sticky error flags and op decode.
// Drives the stack side of the single array write port.
module dat_mem_stk_ctrl
  import dat_mem_pkg::*;
#(
  parameter  int DW        = DW_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int STK_DEPTH = STK_DEPTH_DEF,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          clr_err_i,
  output logic [AW-1:0] sp_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          ovf_o,
  output logic          unf_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [DW-1:0] wdata_o
);

  localparam int CW = $clog2(STK_DEPTH + 1);

  logic [AW-1:0] sp_q, sp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          ovf_set, unf_set;
  stk_op_t       op;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(STK_DEPTH));
  assign sp_o    = sp_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  always_comb begin
    op      = stk_decode(push_i, pop_i, empty_o);
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we_o    = 1'b0;
    waddr_o = sp_q;
    wdata_o = push_dat_i;
    case (op)
      STK_PUSH: begin
        if (!full_o) begin
          we_o  = 1'b1;
          sp_d  = sp_q - 1'b1;
          cnt_d = cnt_q + 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end
      STK_POP: begin
        if (!empty_o) begin
          sp_d  = sp_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      STK_REPL: begin
        we_o    = 1'b1;
        waddr_o = sp_q + 1'b1;
      end
      default: ;
    endcase
    // a fresh error in the clearing cycle keeps the flag set
    ovf_d = ovf_set | (ovf_q & ~clr_err_i);
    unf_d = unf_set | (unf_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sp_q  <= AW'(DEPTH - 1);
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: rtl/dat_mem_stk.sv
// Data memory with load/store port and downward-growing hardware stack.
// Top level: array, combinational read muxes and write-port priority (push > store).
module dat_mem_stk
  import dat_mem_pkg::*;
#(
  parameter  int DW        = DW_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int STK_DEPTH = STK_DEPTH_DEF,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] dat_in_i,
  input  logic          wr_en_i,
  output logic [DW-1:0] dat_out_o,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] tos_o,
  output logic [AW-1:0] sp_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          st_busy_o,
  output logic          ovf_o,
  output logic          unf_o,
  input  logic          clr_err_i
);

  localparam logic [AW-1:0] MADDR [3] = '{AW'(MASK_ADDR_0), AW'(MASK_ADDR_1), AW'(MASK_ADDR_2)};
  localparam logic [DW-1:0] MVAL  [3] = '{DW'(MASK_VAL_0), DW'(MASK_VAL_1), DW'(MASK_VAL_2)};

  logic [DW-1:0] core_q [DEPTH];
  logic [2:0]    mask_dirty_q;

  logic          stk_we;
  logic [AW-1:0] stk_waddr;
  logic [DW-1:0] stk_wdata;
  logic          store_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] tos_addr;

  dat_mem_stk_ctrl #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .STK_DEPTH (STK_DEPTH)
  ) u_ctrl (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push_i),
    .pop_i      (pop_i),
    .push_dat_i (push_dat_i),
    .clr_err_i  (clr_err_i),
    .sp_o       (sp_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .ovf_o      (ovf_o),
    .unf_o      (unf_o),
    .we_o       (stk_we),
    .waddr_o    (stk_waddr),
    .wdata_o    (stk_wdata)
  );

  // any push request owns the write port, even one rejected as overflow
  assign store_we  = wr_en_i && !push_i;
  assign st_busy_o = wr_en_i && push_i;
  assign mem_we    = stk_we || store_we;
  assign mem_waddr = stk_we ? stk_waddr : addr_i;
  assign mem_wdata = stk_we ? stk_wdata : dat_in_i;
  assign tos_addr  = sp_o + 1'b1;

  always_ff @(posedge clk_i) begin
    if (mem_we && rst_n_i) core_q[mem_waddr] <= mem_wdata;
  end

  // mask words read as their constants until first overwritten
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask_dirty_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (mem_we && (mem_waddr == MADDR[i])) mask_dirty_q[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    dat_out_o = core_q[addr_i];
    tos_o     = core_q[tos_addr];
    for (int i = 0; i < 3; i++) begin
      if ((addr_i == MADDR[i]) && !mask_dirty_q[i])   dat_out_o = MVAL[i];
      if ((tos_addr == MADDR[i]) && !mask_dirty_q[i]) tos_o     = MVAL[i];
    end
    if (empty_o) tos_o = '0;
  end

endmodule

// File: tb/tb_dat_mem_stk.sv
// Scoreboard bench for dat_mem_stk: a queue-based stack model predicts each cycle's
// post-edge outputs; a separate monitor pops the predictions and compares.
module tb_dat_mem_stk;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic [7:0] dat_in;
  logic       wr_en;
  logic [7:0] dat_out;
  logic       push;
  logic [7:0] push_dat;
  logic       pop;
  logic [7:0] tos;
  logic [7:0] sp;
  logic       empty;
  logic       full;
  logic       st_busy;
  logic       ovf;
  logic       unf;
  logic       clr_err;

  dat_mem_stk dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .addr_i     (addr),
    .dat_in_i   (dat_in),
    .wr_en_i    (wr_en),
    .dat_out_o  (dat_out),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .tos_o      (tos),
    .sp_o       (sp),
    .empty_o    (empty),
    .full_o     (full),
    .st_busy_o  (st_busy),
    .ovf_o      (ovf),
    .unf_o      (unf),
    .clr_err_i  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sp;
    logic [7:0] tos;
    logic [7:0] dout;
    logic       dknown;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
    logic       busy;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // reference model
  logic [7:0] stk_m[$];
  logic [7:0] mem_m[256];
  bit         known_m[256];
  bit         ovf_m, unf_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk_m.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic do_op(input bit ps, input bit pp, input bit wr, input logic [7:0] a,
                       input logic [7:0] din, input logic [7:0] pd, input bit clr);
    exp_t e;
    bit   eo, eu;
    int   n;
    @(negedge clk);
    push = ps; pop = pp; wr_en = wr; addr = a; dat_in = din; push_dat = pd; clr_err = clr;
    eo = 0; eu = 0;
    n  = stk_m.size();
    if (ps && pp && n > 0) begin
      stk_m[n-1]   = pd;
      mem_m[256-n] = pd;
    end else if (ps) begin
      if (n == 16) eo = 1;
      else begin
        mem_m[255-n] = pd;
        known_m[255-n] = 1;
        stk_m.push_back(pd);
      end
    end else if (pp) begin
      if (n == 0) eu = 1;
      else void'(stk_m.pop_back());
    end
    if (wr && !ps) begin
      mem_m[a]   = din;
      known_m[a] = 1;
    end
    ovf_m = eo | (ovf_m & !clr);
    unf_m = eu | (unf_m & !clr);
    n = stk_m.size();
    e.sp     = 8'(255 - n);
    e.tos    = (n > 0) ? stk_m[n-1] : 8'h00;
    e.dout   = mem_m[a];
    e.dknown = known_m[a];
    e.empty  = (n == 0);
    e.full   = (n == 16);
    e.ovf    = ovf_m;
    e.unf    = unf_m;
    e.busy   = wr && ps;
    sb_q.push_back(e);
  endtask

  task automatic nop(input logic [7:0] a);
    do_op(0, 0, 0, a, 8'h00, 8'h00, 0);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sp",      32'(sp),      32'(e.sp));
        check("tos",     32'(tos),     32'(e.tos));
        check("empty",   32'(empty),   32'(e.empty));
        check("full",    32'(full),    32'(e.full));
        check("ovf",     32'(ovf),     32'(e.ovf));
        check("unf",     32'(unf),     32'(e.unf));
        check("st_busy", 32'(st_busy), 32'(e.busy));
        if (e.dknown) check("dat_out", 32'(dat_out), 32'(e.dout));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ps, pp, wr, clr;
    int r;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) begin
      known_m[i] = 0;
      mem_m[i]   = 8'h00;
    end
    mem_m[60] = 8'h10; known_m[60] = 1;
    mem_m[61] = 8'hE0; known_m[61] = 1;
    mem_m[62] = 8'hF0; known_m[62] = 1;
    model_reset();

    // reset state
    rst_n = 0; push = 0; pop = 0; wr_en = 0; clr_err = 0;
    addr = 8'd61; dat_in = 0; push_dat = 0;
    #12;
    check("rst_sp",    32'(sp),      32'd255);
    check("rst_empty", 32'(empty),   32'd1);
    check("rst_full",  32'(full),    32'd0);
    check("rst_tos",   32'(tos),     32'd0);
    check("rst_ovf",   32'(ovf),     32'd0);
    check("rst_unf",   32'(unf),     32'd0);
    check("rst_mask",  32'(dat_out), 32'hE0);
    @(negedge clk);
    rst_n = 1;

    // store / load
    do_op(0, 0, 1, 8'h05, 8'hA5, 8'h00, 0);
    nop(8'h05);

    // LIFO
    do_op(1, 0, 0, 8'h05, 8'h00, 8'h11, 0);
    do_op(1, 0, 0, 8'h05, 8'h00, 8'h22, 0);
    do_op(1, 0, 0, 8'h05, 8'h00, 8'h33, 0);
    @(posedge clk); #2;
    check("lifo_sp",  32'(sp),  32'd252);
    check("lifo_tos", 32'(tos), 32'h33);
    repeat (3) do_op(0, 1, 0, 8'h05, 8'h00, 8'h00, 0);

    // overflow / underflow / clear
    for (int i = 0; i < 17; i++) do_op(1, 0, 0, 8'h05, 8'h00, 8'(8'hC0 + i), 0);
    @(posedge clk); #2;
    check("ovf_sp",  32'(sp),  32'd239);
    check("ovf_tos", 32'(tos), 32'hCF);
    check("ovf_flg", 32'(ovf), 32'd1);
    repeat (17) do_op(0, 1, 0, 8'h05, 8'h00, 8'h00, 0);
    @(posedge clk); #2;
    check("unf_sp",  32'(sp),  32'd255);
    check("unf_flg", 32'(unf), 32'd1);
    do_op(0, 0, 0, 8'h05, 8'h00, 8'h00, 1);
    // error in the clearing cycle wins
    do_op(0, 1, 0, 8'h05, 8'h00, 8'h00, 1);
    do_op(0, 0, 0, 8'h05, 8'h00, 8'h00, 1);

    // collisions
    do_op(0, 0, 1, 8'd10, 8'h3C, 8'h00, 0);
    do_op(1, 0, 1, 8'd10, 8'h99, 8'h44, 0);
    do_op(1, 1, 0, 8'd10, 8'h00, 8'h55, 0);
    do_op(1, 1, 1, 8'd10, 8'h77, 8'h66, 0);
    do_op(0, 1, 0, 8'd10, 8'h00, 8'h00, 0);
    do_op(1, 1, 0, 8'd10, 8'h00, 8'h5A, 0);
    do_op(0, 1, 0, 8'd10, 8'h00, 8'h00, 0);

    // async reset between edges
    do_op(1, 0, 0, 8'd10, 8'h00, 8'hA1, 0);
    do_op(1, 0, 0, 8'd10, 8'h00, 8'hA2, 0);
    do_op(1, 0, 0, 8'd10, 8'h00, 8'hA3, 0);
    nop(8'd254);
    @(posedge clk); #3;
    rst_n = 0;
    model_reset();
    #1;
    check("arst_sp",    32'(sp),      32'd255);
    check("arst_empty", 32'(empty),   32'd1);
    check("arst_tos",   32'(tos),     32'd0);
    check("arst_mem",   32'(dat_out), 32'hA2);
    @(negedge clk);
    rst_n = 1;

    // random: fill-biased then drain-biased
    for (int k = 0; k < 700; k++) begin
      r  = $urandom_range(0, 99);
      if (k < 350) begin
        ps = (r < 60);
        pp = (r >= 50 && r < 80);
      end else begin
        ps = (r < 25);
        pp = (r >= 15 && r < 75);
      end
      wr  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      a   = 8'($urandom_range(0, 200));
      if (wr && a >= 8'd60 && a <= 8'd62) a = a + 8'd3;
      do_op(ps, pp, wr, a, 8'($urandom), 8'($urandom), clr);
    end
    nop(8'd61);

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
    #3;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
